// File: rtl/pb_io_pkg.sv
// Shared constants for the kcpsm6 port bridge: interrupt register addresses,
// the "no vector" code and the interrupt FSM state encoding.
package pb_io_pkg;

  localparam logic [7:0] ADDR_IRQ_STAT = 8'hF0;
  localparam logic [7:0] ADDR_IRQ_MASK = 8'hF1;
  localparam logic [7:0] ADDR_IRQ_VEC  = 8'hF2;
  localparam logic [7:0] VEC_NONE      = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } irq_state_t;

endpackage

// File: rtl/pb_io_if.sv
// kcpsm6 port bus. Writes are qualified by write_strobe in the cycle port_id/out_port
// are valid (no back-pressure); in_port is a registered reply to port_id, read_strobe is informational.
interface pb_io_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic       interrupt_ack;
  logic [7:0] in_port;
  logic       interrupt;

  modport master (
    output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/pb_irq_ctrl.sv
// Edge-triggered interrupt controller: pending/mask registers, priority vector and
// request FSM. PB_IO_SYNC_EN adds a 2-flop synchroniser on irq_src.
module pb_irq_ctrl
  import pb_io_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             stat_we,
  input  logic             mask_we,
  input  logic [7:0]       wdata,
  input  logic             irq_ack,
  output logic [7:0]       pending_rd,
  output logic [7:0]       mask_rd,
  output logic [7:0]       vector,
  output logic             interrupt,
  output irq_state_t       state
);

  logic [N_IRQ-1:0] src;
  logic [N_IRQ-1:0] src_prev;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] act;
  irq_state_t       state_next;
  logic             unused_wdata;

  assign unused_wdata = ^wdata;

`ifdef PB_IO_SYNC_EN
  logic [N_IRQ-1:0] src_s1;
  logic [N_IRQ-1:0] src_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_s1 <= '0;
      src_s2 <= '0;
    end else begin
      src_s1 <= irq_src;
      src_s2 <= src_s1;
    end
  end

  assign src = src_s2;
`else
  assign src = irq_src;
`endif

  assign rise = src & ~src_prev;
  assign clr  = stat_we ? wdata[N_IRQ-1:0] : '0;
  assign act  = pending & mask;

  // A rising edge in the same cycle as a W1C of that bit keeps the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_prev <= '0;
      pending  <= '0;
      mask     <= '0;
    end else begin
      src_prev <= src;
      pending  <= (pending & ~clr) | rise;
      if (mask_we) begin
        mask <= wdata[N_IRQ-1:0];
      end
    end
  end

  always_comb begin
    pending_rd = 8'h00;
    mask_rd    = 8'h00;
    for (int i = 0; i < N_IRQ; i++) begin
      pending_rd[i] = pending[i];
      mask_rd[i]    = mask[i];
    end
  end

  // Lowest index wins, so scan downwards and let the last hit stand.
  always_comb begin
    vector = VEC_NONE;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (act[i]) begin
        vector = 8'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    interrupt  = 1'b0;
    case (state)
      IDLE: begin
        if (|act) begin
          state_next = REQ;
        end
      end
      REQ: begin
        interrupt = 1'b1;
        if (irq_ack) begin
          state_next = SERV;
        end else if (~|act) begin
          state_next = IDLE;
        end
      end
      SERV: begin
        if (~|act) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/pb_io_bridge.sv
// kcpsm6 port decode / input mux / key decode bridge with an interrupt controller.
// PB_IO_SYNC_EN adds 2-flop synchronisers on in_ch and irq_src.
module pb_io_bridge
  import pb_io_pkg::*;
#(
  parameter int         N_OUT    = 4,
  parameter int         N_IN     = 4,
  parameter int         N_IRQ    = 4,
  parameter logic [7:0] KEY_PORT = 8'h01,
  parameter logic [7:0] KEY_INC  = 8'h1D,
  parameter logic [7:0] KEY_DEC  = 8'h1B
) (
  input  logic              clk,
  input  logic              reset,
  pb_io_if.slave            bus,
  input  logic [8*N_IN-1:0] in_ch,
  input  logic [N_IRQ-1:0]  irq_src,
  output logic [8*N_OUT-1:0] out_regs,
  output logic [N_OUT-1:0]  out_wr,
  output logic              inc_pulse,
  output logic              dec_pulse,
  output irq_state_t        irq_state
);

  logic [8*N_IN-1:0] ch;
  logic [7:0]        pending_rd;
  logic [7:0]        mask_rd;
  logic [7:0]        vector;
  logic [7:0]        rd_mux;
  logic              stat_we;
  logic              mask_we;
  logic              key_wr;
  logic              unused_rd;

  assign unused_rd = bus.read_strobe;

`ifdef PB_IO_SYNC_EN
  logic [8*N_IN-1:0] ch_s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_s1 <= '0;
      ch    <= '0;
    end else begin
      ch_s1 <= in_ch;
      ch    <= ch_s1;
    end
  end
`else
  assign ch = in_ch;
`endif

  assign stat_we = bus.write_strobe && (bus.port_id == ADDR_IRQ_STAT);
  assign mask_we = bus.write_strobe && (bus.port_id == ADDR_IRQ_MASK);
  assign key_wr  = bus.write_strobe && (bus.port_id == KEY_PORT);

  pb_irq_ctrl #(
    .N_IRQ(N_IRQ)
  ) u_irq (
    .clk       (clk),
    .rst       (reset),
    .irq_src   (irq_src),
    .stat_we   (stat_we),
    .mask_we   (mask_we),
    .wdata     (bus.out_port),
    .irq_ack   (bus.interrupt_ack),
    .pending_rd(pending_rd),
    .mask_rd   (mask_rd),
    .vector    (vector),
    .interrupt (bus.interrupt),
    .state     (irq_state)
  );

  always_comb begin
    rd_mux = 8'h00;
    if (bus.port_id == ADDR_IRQ_STAT) begin
      rd_mux = pending_rd;
    end else if (bus.port_id == ADDR_IRQ_MASK) begin
      rd_mux = mask_rd;
    end else if (bus.port_id == ADDR_IRQ_VEC) begin
      rd_mux = vector;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (bus.port_id == 8'(i)) begin
          rd_mux = ch[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_regs    <= '0;
      out_wr      <= '0;
      inc_pulse   <= 1'b0;
      dec_pulse   <= 1'b0;
      bus.in_port <= 8'h00;
    end else begin
      out_wr <= '0;
      for (int i = 0; i < N_OUT; i++) begin
        if (bus.write_strobe && (bus.port_id == 8'(i))) begin
          out_regs[8*i +: 8] <= bus.out_port;
          out_wr[i]          <= 1'b1;
        end
      end
      inc_pulse   <= key_wr && (bus.out_port == KEY_INC);
      dec_pulse   <= key_wr && (bus.out_port == KEY_DEC);
      bus.in_port <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pb_io_bridge.sv
// Directed bench for pb_io_bridge (default build, PB_IO_SYNC_EN undefined).
module tb_pb_io_bridge;
  import pb_io_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] in_ch;
  logic [3:0]  irq_src;
  logic [31:0] out_regs;
  logic [3:0]  out_wr;
  logic        inc_pulse;
  logic        dec_pulse;
  irq_state_t  irq_state;

  int checks;
  int failures;
  logic [7:0] exp_q[$];

  pb_io_if bus ();

  pb_io_bridge dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .in_ch    (in_ch),
    .irq_src  (irq_src),
    .out_regs (out_regs),
    .out_wr   (out_wr),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse),
    .irq_state(irq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Strobe for one clock; returns on the negedge after the capturing posedge.
  task automatic bus_write(input logic [7:0] id, input logic [7:0] data);
    @(negedge clk);
    bus.port_id      = id;
    bus.out_port     = data;
    bus.write_strobe = 1'b1;
    @(negedge clk);
    bus.write_strobe = 1'b0;
  endtask

  task automatic read_expect(input logic [7:0] id, input logic [7:0] exp, input string tag);
    exp_q.push_back(exp);
    @(negedge clk);
    bus.port_id     = id;
    bus.read_strobe = 1'b1;
    @(negedge clk);
    bus.read_strobe = 1'b0;
    check(tag, bus.in_port, exp_q.pop_front());
  endtask

  task automatic wait_state(input irq_state_t s, input int budget, input string tag);
    int n = 0;
    while (irq_state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, irq_state, s);
  endtask

  task automatic ack_irq();
    @(negedge clk);
    bus.interrupt_ack = 1'b1;
    @(negedge clk);
    bus.interrupt_ack = 1'b0;
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    reset             = 1'b1;
    in_ch             = '0;
    irq_src           = '0;
    bus.port_id       = 8'h00;
    bus.out_port      = 8'h00;
    bus.write_strobe  = 1'b0;
    bus.read_strobe   = 1'b0;
    bus.interrupt_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_out_regs", out_regs, 32'h0);
    check("rst_out_wr", out_wr, 4'h0);
    check("rst_in_port", bus.in_port, 8'h00);
    check("rst_interrupt", bus.interrupt, 1'b0);
    check("rst_pulses", {inc_pulse, dec_pulse}, 2'b00);
    check("rst_state", irq_state, IDLE);
    read_expect(ADDR_IRQ_MASK, 8'h00, "rst_mask");
    read_expect(ADDR_IRQ_STAT, 8'h00, "rst_pending");
    read_expect(ADDR_IRQ_VEC, VEC_NONE, "rst_vector");

    // output register write
    bus_write(8'h02, 8'h55);
    check("wr2_regs", out_regs, 32'h0055_0000);
    check("wr2_out_wr", out_wr, 4'b0100);
    @(negedge clk);
    check("wr2_out_wr_end", out_wr, 4'b0000);
    bus_write(8'h40, 8'hEE);
    check("unmapped_regs", out_regs, 32'h0055_0000);
    check("unmapped_out_wr", out_wr, 4'b0000);

    // key decode
    bus_write(8'h01, 8'h1D);
    check("key_inc", {inc_pulse, dec_pulse}, 2'b10);
    check("key_inc_wr", out_wr, 4'b0010);
    @(negedge clk);
    check("key_inc_end", {inc_pulse, dec_pulse}, 2'b00);
    bus_write(8'h01, 8'h1B);
    check("key_dec", {inc_pulse, dec_pulse}, 2'b01);
    @(negedge clk);
    check("key_dec_end", {inc_pulse, dec_pulse}, 2'b00);
    bus_write(8'h01, 8'h20);
    check("key_other", {inc_pulse, dec_pulse}, 2'b00);
    check("key_other_regs", out_regs, 32'h0055_2000);
    bus_write(8'h03, 8'h1D);
    check("key_wrong_port", {inc_pulse, dec_pulse}, 2'b00);
    check("wr3_regs", out_regs, 32'h1D55_2000);

    // input mux
    in_ch = 32'hA7_3C_5A_11;
    read_expect(8'h03, 8'hA7, "in_ch3");
    read_expect(8'h40, 8'h00, "in_unmapped");
    read_expect(8'h00, 8'h11, "in_ch0");
    read_expect(8'h02, 8'h3C, "in_ch2");

    // two sources rise together, serviced in priority order
    bus_write(ADDR_IRQ_MASK, 8'h0F);
    read_expect(ADDR_IRQ_MASK, 8'h0F, "mask_rd");
    irq_src = 4'b0110;
    wait_state(REQ, 5, "t4_req");
    check("t4_interrupt", bus.interrupt, 1'b1);
    irq_src = 4'b0000;
    read_expect(ADDR_IRQ_STAT, 8'h06, "t4_pending");
    read_expect(ADDR_IRQ_VEC, 8'h01, "t4_vec1");
    ack_irq();
    check("t4_ack_int", bus.interrupt, 1'b0);
    check("t4_ack_state", irq_state, SERV);
    bus_write(ADDR_IRQ_STAT, 8'h02);
    check("t4_w1c2_state", irq_state, SERV);
    read_expect(ADDR_IRQ_VEC, 8'h02, "t4_vec2");
    bus_write(ADDR_IRQ_STAT, 8'h04);
    wait_state(IDLE, 4, "t4_idle");
    read_expect(ADDR_IRQ_VEC, VEC_NONE, "t4_vec_none");
    check("t4_idle_int", bus.interrupt, 1'b0);

    // new edge during service is held until the ISR returns
    irq_src = 4'b0010;
    wait_state(REQ, 5, "t5_req");
    ack_irq();
    check("t5_serv", irq_state, SERV);
    irq_src = 4'b0011;
    repeat (3) @(negedge clk);
    check("t5_no_reentry", bus.interrupt, 1'b0);
    check("t5_still_serv", irq_state, SERV);
    read_expect(ADDR_IRQ_STAT, 8'h03, "t5_pending");
    bus_write(ADDR_IRQ_STAT, 8'h02);
    check("t5_w1c_serv", irq_state, SERV);
    read_expect(ADDR_IRQ_VEC, 8'h00, "t5_vec0");
    bus_write(ADDR_IRQ_STAT, 8'h01);
    wait_state(IDLE, 4, "t5_idle");
    irq_src = 4'b0000;
    @(negedge clk);
    irq_src = 4'b0001;
    wait_state(REQ, 5, "t5_req_again");
    check("t5_interrupt", bus.interrupt, 1'b1);
    ack_irq();
    bus_write(ADDR_IRQ_STAT, 8'h01);
    wait_state(IDLE, 4, "t5_idle2");
    irq_src = 4'b0000;
    @(negedge clk);

    // rising edge and W1C in the same cycle: set wins
    @(negedge clk);
    bus.port_id      = ADDR_IRQ_STAT;
    bus.out_port     = 8'h08;
    bus.write_strobe = 1'b1;
    irq_src          = 4'b1000;
    @(negedge clk);
    bus.write_strobe = 1'b0;
    read_expect(ADDR_IRQ_STAT, 8'h08, "t6_set_wins");
    wait_state(REQ, 5, "t6_req");

    // reset mid-request
    #2 reset = 1'b1;
    #1;
    check("t6_rst_int", bus.interrupt, 1'b0);
    check("t6_rst_state", irq_state, IDLE);
    check("t6_rst_regs", out_regs, 32'h0);
    irq_src = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_post_pulses", {inc_pulse, dec_pulse}, 2'b00);
    check("t6_post_out_wr", out_wr, 4'h0);
    read_expect(ADDR_IRQ_MASK, 8'h00, "t6_mask");
    read_expect(ADDR_IRQ_STAT, 8'h00, "t6_pending");
    check("t6_post_int", bus.interrupt, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
